// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with tick strobes
//
// Produces NUM_CH independent square-wave clocks from clkIn. Each channel counts
// up to its active half-period value; at that terminal count its output toggles.
// New half-periods are held pending and only applied at a terminal count, so a
// running output never gets a truncated or stretched phase.
//
// Ports:
//   clkIn   - system clock, all state updates on its rising edge
//   rst     - synchronous active-high reset
//   en      - per-channel run enable (level)
//   ldEn    - load strobe for one channel per cycle
//   ldCh    - channel addressed by ldEn (values >= NUM_CH are ignored)
//   ldVal   - new half-period terminal count
//   clkOut  - divided clocks, registered
//   tick    - one-cycle pulse in the first cycle clkOut reads high after rising
//   pend    - channel holds a loaded value that has not been applied yet
module clk_div_multi #(
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 2,
  parameter int CNT_W        = 26,
  parameter int DEFAULT_HALF = 1250000
) (
  input  logic              clkIn,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              ldEn,
  input  logic [CH_W-1:0]   ldCh,
  input  logic [CNT_W-1:0]  ldVal,
  output logic [NUM_CH-1:0] clkOut,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  act_q [NUM_CH];
  logic [CNT_W-1:0]  act_d [NUM_CH];
  logic [CNT_W-1:0]  pv_q  [NUM_CH];
  logic [CNT_W-1:0]  pv_d  [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sel, term;

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pv_d   = pv_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = '0;
    sel    = '0;
    term   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Only addresses below NUM_CH can ever match, so out-of-range ldCh is a no-op.
      sel[i]  = ldEn && (ldCh == CH_W'(i));
      term[i] = (cnt_q[i] == act_q[i]);
      if (!en[i]) begin
        // Stopped channel: nothing is mid-phase, so a load takes effect at once.
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (sel[i]) begin
          act_d[i]  = ldVal;
          pend_d[i] = 1'b0;
        end
      end else if (term[i]) begin
        cnt_d[i]  = '0;
        clk_d[i]  = ~clk_q[i];
        tick_d[i] = ~clk_q[i];
        pend_d[i] = 1'b0;
        // A load arriving on the terminal cycle is newer than any pending value.
        if (sel[i]) begin
          act_d[i] = ldVal;
        end else if (pend_q[i]) begin
          act_d[i] = pv_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (sel[i]) begin
          pv_d[i]   = ldVal;
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= RST_HALF;
        pv_q[i]  <= '0;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pv_q   <= pv_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clkOut = clk_q;
  assign tick   = tick_q;
  assign pend   = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
module tb_clk_div_multi;

  logic       clk_in;
  logic       rst;
  logic [3:0] en;
  logic       ld_en;
  logic [2:0] ld_ch;
  logic [7:0] ld_val;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic [3:0] pend;

  int checks;
  int failures;

  clk_div_multi #(
    .NUM_CH(4),
    .CH_W(3),
    .CNT_W(8),
    .DEFAULT_HALF(3)
  ) dut (
    .clkIn (clk_in),
    .rst   (rst),
    .en    (en),
    .ldEn  (ld_en),
    .ldCh  (ld_ch),
    .ldVal (ld_val),
    .clkOut(clk_out),
    .tick  (tick),
    .pend  (pend)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 4'h0;
    ld_en    = 1'b0;
    ld_ch    = 3'd0;
    ld_val   = 8'd0;
    @(negedge clk_in);
    step();
    step();
    chk("reset_clk", clk_out, 4'h0);
    chk("reset_tick", tick, 4'h0);
    chk("reset_pend", pend, 4'h0);

    // Default half-period 3: toggle every 4 edges, rise at edge 4, tick every 8.
    rst = 1'b0;
    en  = 4'hF;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("dflt_clk", clk_out, ((k / 4) % 2 == 1) ? 4'hF : 4'h0);
      chk("dflt_tick", tick, (k % 8 == 4) ? 4'hF : 4'h0);
    end

    // Minimum divide on ch1: loaded 0 while disabled.
    en[1]  = 1'b0;
    ld_en  = 1'b1;
    ld_ch  = 3'd1;
    ld_val = 8'd0;
    step();
    ld_en = 1'b0;
    chk("min_dis_clk", {3'b0, clk_out[1]}, 4'h0);
    chk("min_dis_pend", {3'b0, pend[1]}, 4'h0);
    en[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("min_clk", {3'b0, clk_out[1]}, (k % 2 == 1) ? 4'h1 : 4'h0);
      chk("min_tick", {3'b0, tick[1]}, (k % 2 == 1) ? 4'h1 : 4'h0);
    end

    // Deferred load on ch0: sampled at cnt=1, applied at the cnt=3 terminal.
    en[0] = 1'b0;
    step();
    en[0] = 1'b1;
    step();
    ld_en  = 1'b1;
    ld_ch  = 3'd0;
    ld_val = 8'd9;
    step();
    ld_en = 1'b0;
    chk("def_pend_set", {3'b0, pend[0]}, 4'h1);
    chk("def_clk_low", {3'b0, clk_out[0]}, 4'h0);
    step();
    chk("def_pend_hold", {3'b0, pend[0]}, 4'h1);
    step();
    chk("def_rise", {3'b0, clk_out[0]}, 4'h1);
    chk("def_rise_tick", {3'b0, tick[0]}, 4'h1);
    chk("def_pend_clr", {3'b0, pend[0]}, 4'h0);
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("def_clk", {3'b0, clk_out[0]}, (j < 10 || j == 20) ? 4'h1 : 4'h0);
      chk("def_tick", {3'b0, tick[0]}, (j == 20) ? 4'h1 : 4'h0);
    end

    // Collision on ch2: pv=9 pending, ldVal=5 arrives on the terminal cycle.
    en[2] = 1'b0;
    step();
    en[2] = 1'b1;
    step();
    ld_en  = 1'b1;
    ld_ch  = 3'd2;
    ld_val = 8'd9;
    step();
    ld_en = 1'b0;
    chk("col_pend_set", {3'b0, pend[2]}, 4'h1);
    step();
    ld_en  = 1'b1;
    ld_val = 8'd5;
    step();
    ld_en = 1'b0;
    chk("col_rise", {3'b0, clk_out[2]}, 4'h1);
    chk("col_pend_clr", {3'b0, pend[2]}, 4'h0);
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("col_clk", {3'b0, clk_out[2]}, (j < 6 || j == 12) ? 4'h1 : 4'h0);
      chk("col_tick", {3'b0, tick[2]}, (j == 12) ? 4'h1 : 4'h0);
    end

    // Disable ch3 while high, with a load to nonexistent channel 7.
    en[3] = 1'b0;
    step();
    en[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("dis_pre_clk", {3'b0, clk_out[3]}, (k == 4) ? 4'h1 : 4'h0);
    end
    en[3]  = 1'b0;
    ld_en  = 1'b1;
    ld_ch  = 3'd7;
    ld_val = 8'd0;
    step();
    ld_en = 1'b0;
    chk("dis_force_low", {3'b0, clk_out[3]}, 4'h0);
    chk("dis_tick", {3'b0, tick[3]}, 4'h0);
    chk("bad_ch_pend", pend, 4'h0);
    step();
    chk("dis_stay_low", {3'b0, clk_out[3]}, 4'h0);
    step();
    chk("dis_stay_low2", {3'b0, clk_out[3]}, 4'h0);
    en[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("reen_clk", {3'b0, clk_out[3]}, (k == 4) ? 4'h1 : 4'h0);
      chk("reen_tick", {3'b0, tick[3]}, (k == 4) ? 4'h1 : 4'h0);
    end

    // Reset mid-operation with ch0 pending at cnt=2, plus a simultaneous load.
    en[0] = 1'b0;
    step();
    en[0] = 1'b1;
    step();
    ld_en  = 1'b1;
    ld_ch  = 3'd0;
    ld_val = 8'd20;
    step();
    ld_en = 1'b0;
    chk("mid_pend_set", {3'b0, pend[0]}, 4'h1);
    rst    = 1'b1;
    ld_en  = 1'b1;
    ld_ch  = 3'd1;
    ld_val = 8'd0;
    step();
    chk("mid_rst_clk", clk_out, 4'h0);
    chk("mid_rst_tick", tick, 4'h0);
    chk("mid_rst_pend", pend, 4'h0);
    rst   = 1'b0;
    ld_en = 1'b0;
    en    = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("post_rst_clk", clk_out, ((k / 4) % 2 == 1) ? 4'hF : 4'h0);
      chk("post_rst_tick", tick, (k % 8 == 4) ? 4'hF : 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
